// File: rtl/lock_pkg.sv
// Shared types and constants for the switch-code combination lock.
package lock_pkg;

    localparam int unsigned DIGIT_W       = 4;
    localparam int unsigned LED_W         = 8;
    localparam int unsigned IDX_W         = 2;
    localparam int unsigned FAIL_W        = 2;
    localparam int unsigned LED_BIT_W     = 3;
    localparam int unsigned LED_PROG_BASE = 2;

    localparam logic [DIGIT_W-1:0] NEUTRAL     = 4'hF;
    localparam logic [LED_W-1:0]   LED_OPEN    = 8'hFF;
    localparam logic [LED_W-1:0]   LED_LOCKOUT = 8'h01;
    localparam logic [LED_W-1:0]   LED_PROG    = 8'h80;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HELD     = 3'd1,
        S_OPEN     = 3'd2,
        S_PROG     = 3'd3,
        S_LOCKOUT  = 3'd4,
        S_WAIT_REL = 3'd5
    } state_t;

endpackage

// File: rtl/lock_press_detect.sv
// Edge detector for the switch bank: one-cycle press/release pulses relative to neutral.
module lock_press_detect
    import lock_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  digit_t i_switch,
    output logic   press_c,
    output logic   release_c,
    output digit_t value_c
);

    digit_t sw_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sw_q <= NEUTRAL;
        end else begin
            sw_q <= i_switch;
        end
    end

    // Changes between two non-neutral values are neither press nor release.
    always_comb begin
        press_c   = (sw_q == NEUTRAL) && (i_switch != NEUTRAL);
        release_c = (sw_q != NEUTRAL) && (i_switch == NEUTRAL);
        value_c   = i_switch;
    end

endmodule

// File: rtl/lock_attempt_controller.sv
// Combination-lock supervisor: digit entry, attempt comparison, lockout timing and
// code reprogramming, driving the board LEDs.
module lock_attempt_controller
    import lock_pkg::*;
#(
    parameter int unsigned CODE_LEN       = 4,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 50000,
    parameter logic [15:0] DEFAULT_CODE   = 16'h7BDE
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [3:0]       i_switch,
    input  logic             i_prog,
    output logic [LED_W-1:0] o_led,
    output logic             o_unlocked,
    output logic             o_locked_out,
    output logic [1:0]       o_fail_cnt
);

    localparam int unsigned TIMER_W    = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int unsigned FAIL_EXT_W = FAIL_W + 1;

    localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(CODE_LEN - 1);
    localparam logic [FAIL_EXT_W-1:0] FAIL_LIMIT  = FAIL_EXT_W'(MAX_FAILS);
    localparam logic [TIMER_W-1:0]    TIMER_START = TIMER_W'(LOCKOUT_CYCLES - 1);

    state_t                state_q;
    digit_t                code_q   [CODE_LEN];
    digit_t                shadow_q [CODE_LEN];
    logic [IDX_W-1:0]      idx_q;
    logic                  err_q;
    logic                  prog_held_q;
    logic [FAIL_W-1:0]     fail_q;
    logic [TIMER_W-1:0]    timer_q;
    logic [LED_W-1:0]      led_q;
    logic                  unlocked_q;
    logic                  locked_out_q;

    logic                  press_c;
    logic                  release_c;
    digit_t                value_c;
    logic                  digit_bad_c;
    logic [LED_BIT_W-1:0]  led_bit_c;
    logic [FAIL_EXT_W-1:0] fail_next_c;

    lock_press_detect u_press_detect (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_switch  (i_switch),
        .press_c   (press_c),
        .release_c (release_c),
        .value_c   (value_c)
    );

    always_comb begin
        digit_bad_c = (value_c != code_q[idx_q]);
        led_bit_c   = LED_BIT_W'(LED_PROG_BASE) + LED_BIT_W'(idx_q);
        fail_next_c = FAIL_EXT_W'(fail_q) + FAIL_EXT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            err_q        <= 1'b0;
            prog_held_q  <= 1'b0;
            fail_q       <= '0;
            timer_q      <= '0;
            led_q        <= '0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
            for (int k = 0; k < CODE_LEN; k++) begin
                code_q[k]   <= DEFAULT_CODE[4*k +: 4];
                shadow_q[k] <= NEUTRAL;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (press_c) begin
                        err_q   <= err_q | digit_bad_c;
                        state_q <= S_HELD;
                    end
                end

                // Verdict is withheld until the last digit so a wrong digit is never revealed early.
                S_HELD: begin
                    if (release_c) begin
                        if (idx_q != LAST_IDX) begin
                            led_q[led_bit_c] <= 1'b1;
                            idx_q            <= idx_q + IDX_W'(1);
                            state_q          <= S_IDLE;
                        end else begin
                            idx_q <= '0;
                            err_q <= 1'b0;
                            if (!err_q) begin
                                state_q    <= S_OPEN;
                                fail_q     <= '0;
                                led_q      <= LED_OPEN;
                                unlocked_q <= 1'b1;
                            end else if (fail_next_c == FAIL_LIMIT) begin
                                state_q      <= S_LOCKOUT;
                                timer_q      <= TIMER_START;
                                fail_q       <= FAIL_W'(MAX_FAILS);
                                led_q        <= LED_LOCKOUT;
                                locked_out_q <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                fail_q  <= fail_q + FAIL_W'(1);
                                led_q   <= '0;
                            end
                        end
                    end
                end

                S_OPEN: begin
                    if (i_prog) begin
                        state_q     <= S_PROG;
                        idx_q       <= '0;
                        prog_held_q <= 1'b0;
                        led_q       <= LED_PROG;
                        unlocked_q  <= 1'b0;
                    end else if (press_c) begin
                        state_q    <= S_WAIT_REL;
                        led_q      <= '0;
                        unlocked_q <= 1'b0;
                    end
                end

                // A release only counts if its press was captured here, so a press
                // discarded on entry cannot advance the programming index.
                S_PROG: begin
                    if (press_c && !prog_held_q) begin
                        shadow_q[idx_q] <= value_c;
                        prog_held_q     <= 1'b1;
                    end else if (release_c && prog_held_q) begin
                        prog_held_q <= 1'b0;
                        if (idx_q != LAST_IDX) begin
                            led_q[led_bit_c] <= 1'b1;
                            idx_q            <= idx_q + IDX_W'(1);
                        end else begin
                            for (int k = 0; k < CODE_LEN; k++) begin
                                code_q[k] <= shadow_q[k];
                            end
                            idx_q   <= '0;
                            led_q   <= '0;
                            state_q <= S_IDLE;
                        end
                    end
                end

                S_LOCKOUT: begin
                    if (timer_q == '0) begin
                        fail_q       <= '0;
                        led_q        <= '0;
                        locked_out_q <= 1'b0;
                        state_q      <= (i_switch == NEUTRAL) ? S_IDLE : S_WAIT_REL;
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end

                S_WAIT_REL: begin
                    if (i_switch == NEUTRAL) begin
                        state_q <= S_IDLE;
                        idx_q   <= '0;
                        err_q   <= 1'b0;
                        led_q   <= '0;
                    end
                end

                default: begin
                    state_q      <= S_IDLE;
                    idx_q        <= '0;
                    err_q        <= 1'b0;
                    prog_held_q  <= 1'b0;
                    led_q        <= '0;
                    unlocked_q   <= 1'b0;
                    locked_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_led        = led_q;
    assign o_unlocked   = unlocked_q;
    assign o_locked_out = locked_out_q;
    assign o_fail_cnt   = fail_q;

endmodule

// File: tb/tb_lock_attempt_controller.sv
// Directed bench for lock_attempt_controller with a queue-based attempt model checked every cycle.
module tb_lock_attempt_controller;

    localparam int unsigned CODE_LEN       = 4;
    localparam int unsigned MAX_FAILS      = 3;
    localparam int unsigned LOCKOUT_CYCLES = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       prog;
    logic [7:0] led;
    logic       unlocked;
    logic       locked_out;
    logic [1:0] fail_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lock_attempt_controller #(
        .CODE_LEN       (CODE_LEN),
        .MAX_FAILS      (MAX_FAILS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .DEFAULT_CODE   (16'h7BDE)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_switch     (sw),
        .i_prog       (prog),
        .o_led        (led),
        .o_unlocked   (unlocked),
        .o_locked_out (locked_out),
        .o_fail_cnt   (fail_cnt)
    );

    // Behavioural model: attempts are collected as digit queues and judged whole.
    typedef enum int {M_READY, M_HOLD, M_OPEN, M_PROG, M_LOCK, M_WAIT} mmode_t;

    mmode_t     m_mode;
    logic [3:0] m_code [CODE_LEN];
    logic [3:0] m_attempt [$];
    logic [3:0] m_newcode [$];
    int         m_fails;
    int         m_done;
    int         m_lock_left;
    bit         m_prog_hold;
    bit         m_valid = 1'b0;
    logic [3:0] m_prev;
    logic [3:0] m_s;
    bit         m_pr;
    bit         m_rl;
    bit         m_match;

    function automatic logic [7:0] progress_mask(int n);
        logic [7:0] ones;
        ones = 8'((1 << n) - 1);
        return ones << 2;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode      = M_READY;
            m_code      = '{4'hE, 4'hD, 4'hB, 4'h7};
            m_attempt.delete();
            m_newcode.delete();
            m_fails     = 0;
            m_done      = 0;
            m_lock_left = 0;
            m_prog_hold = 1'b0;
            m_prev      = 4'hF;
        end else begin
            m_s  = sw;
            m_pr = (m_prev == 4'hF) && (m_s != 4'hF);
            m_rl = (m_prev != 4'hF) && (m_s == 4'hF);
            case (m_mode)
                M_READY: if (m_pr) begin
                    m_attempt.push_back(m_s);
                    m_mode = M_HOLD;
                end
                M_HOLD: if (m_rl) begin
                    m_done++;
                    m_mode = M_READY;
                    if (m_done == CODE_LEN) begin
                        m_match = 1'b1;
                        for (int i = 0; i < CODE_LEN; i++)
                            if (m_attempt[i] != m_code[i]) m_match = 1'b0;
                        m_attempt.delete();
                        m_done = 0;
                        if (m_match) begin
                            m_mode  = M_OPEN;
                            m_fails = 0;
                        end else if (m_fails + 1 == MAX_FAILS) begin
                            m_mode      = M_LOCK;
                            m_fails     = MAX_FAILS;
                            m_lock_left = LOCKOUT_CYCLES;
                        end else begin
                            m_fails++;
                        end
                    end
                end
                M_OPEN: begin
                    if (prog) begin
                        m_mode      = M_PROG;
                        m_newcode.delete();
                        m_done      = 0;
                        m_prog_hold = 1'b0;
                    end else if (m_pr) begin
                        m_mode = M_WAIT;
                    end
                end
                M_PROG: begin
                    if (m_pr) begin
                        m_newcode.push_back(m_s);
                        m_prog_hold = 1'b1;
                    end else if (m_rl && m_prog_hold) begin
                        m_prog_hold = 1'b0;
                        m_done++;
                        if (m_done == CODE_LEN) begin
                            for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_newcode[i];
                            m_done = 0;
                            m_mode = M_READY;
                        end
                    end
                end
                M_LOCK: begin
                    m_lock_left--;
                    if (m_lock_left == 0) begin
                        m_fails = 0;
                        m_mode  = (m_s == 4'hF) ? M_READY : M_WAIT;
                    end
                end
                M_WAIT: if (m_s == 4'hF) m_mode = M_READY;
                default: m_mode = M_READY;
            endcase
            m_prev = m_s;
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        logic [7:0] e_led;
        if (m_valid) begin
            case (m_mode)
                M_OPEN:  e_led = 8'hFF;
                M_LOCK:  e_led = 8'h01;
                M_PROG:  e_led = 8'h80 | progress_mask(m_done);
                M_WAIT:  e_led = 8'h00;
                default: e_led = progress_mask(m_done);
            endcase
            checks++;
            if (led !== e_led || unlocked !== (m_mode == M_OPEN) ||
                locked_out !== (m_mode == M_LOCK) || fail_cnt !== 2'(m_fails)) begin
                failures++;
                $display("FAIL model t=%0t led=%h exp=%h unl=%b exp=%b lko=%b exp=%b fails=%0d exp=%0d",
                         $time, led, e_led, unlocked, (m_mode == M_OPEN), locked_out,
                         (m_mode == M_LOCK), fail_cnt, m_fails);
            end
        end
    end

    task automatic check_lit(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic enter(input logic [3:0] d);
        sw = d;
        cycle();
        sw = 4'hF;
        cycle();
    endtask

    // Digits are entered lowest nibble first.
    task automatic enter_code(input logic [15:0] c);
        for (int k = 0; k < 4; k++) enter(c[4*k +: 4]);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        sw    = 4'hF;
        prog  = 1'b0;
        cycle();
        cycle();
        check_lit("rst_led", led, 8'h00);
        check_lit("rst_unlocked", 8'(unlocked), 8'h00);
        check_lit("rst_fail_cnt", 8'(fail_cnt), 8'h00);
        rst_n = 1'b1;

        // Correct code with progress LEDs.
        enter(4'hE); check_lit("prog_led_1", led, 8'h04);
        enter(4'hD); check_lit("prog_led_2", led, 8'h0C);
        enter(4'hB); check_lit("prog_led_3", led, 8'h1C);
        enter(4'h7);
        check_lit("open_unlocked", 8'(unlocked), 8'h01);
        check_lit("open_led", led, 8'hFF);
        check_lit("open_fail_cnt", 8'(fail_cnt), 8'h00);

        // Relock press is not a digit.
        sw = 4'hE; cycle();
        check_lit("relock_unlocked", 8'(unlocked), 8'h00);
        sw = 4'hF; cycle();
        enter_code(16'h7BDE);
        check_lit("relock_reentry", 8'(unlocked), 8'h01);

        // Program request wins over a same-edge press.
        sw = 4'h3; prog = 1'b1; cycle();
        prog = 1'b0;
        check_lit("prog_enter_led", led, 8'h80);
        sw = 4'hF; cycle();
        check_lit("prog_discard_led", led, 8'h80);
        enter(4'h1); check_lit("prog_digit1_led", led, 8'h84);
        enter(4'h2); enter(4'h4); enter(4'h8);
        check_lit("prog_done_led", led, 8'h00);
        enter_code(16'h7BDE);
        check_lit("old_code_fail", 8'(fail_cnt), 8'h01);
        check_lit("old_code_locked", 8'(unlocked), 8'h00);
        enter_code(16'h8421);
        check_lit("new_code_unlocked", 8'(unlocked), 8'h01);
        check_lit("new_code_fail", 8'(fail_cnt), 8'h00);

        // Reset restores the default code.
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        enter_code(16'h7BDE);
        check_lit("rst_default_code", 8'(unlocked), 8'h01);
        enter(4'hE);

        // Wrong digit in the middle: no early rejection.
        enter(4'hE); enter(4'h3);
        check_lit("wrong_mid_led", led, 8'h0C);
        enter(4'hB); enter(4'h7);
        check_lit("wrong_fail_cnt", 8'(fail_cnt), 8'h01);
        check_lit("wrong_led", led, 8'h00);
        check_lit("wrong_unlocked", 8'(unlocked), 8'h00);
        enter_code(16'h7BDE);
        check_lit("after_wrong_unlock", 8'(unlocked), 8'h01);
        check_lit("after_wrong_fail", 8'(fail_cnt), 8'h00);
        enter(4'hE);

        // Lockout after three failures; presses during lockout ignored.
        repeat (3) enter_code(16'h1111);
        check_lit("lockout_flag", 8'(locked_out), 8'h01);
        check_lit("lockout_led", led, 8'h01);
        check_lit("lockout_fail_cnt", 8'(fail_cnt), 8'h03);
        enter(4'hE);
        repeat (5) cycle();
        check_lit("lockout_cycle7", 8'(locked_out), 8'h01);
        cycle();
        check_lit("lockout_expired", 8'(locked_out), 8'h00);
        check_lit("lockout_fail_clr", 8'(fail_cnt), 8'h00);
        enter_code(16'h7BDE);
        check_lit("post_lockout_unlock", 8'(unlocked), 8'h01);
        enter(4'hE);

        // Lockout expiring while a switch is held.
        repeat (3) enter_code(16'h1111);
        sw = 4'hE;
        repeat (7) cycle();
        check_lit("held_lockout_cycle7", 8'(locked_out), 8'h01);
        cycle();
        check_lit("held_lockout_expired", 8'(locked_out), 8'h00);
        cycle(); cycle();
        check_lit("held_wait_led", led, 8'h00);
        sw = 4'hF; cycle();
        enter_code(16'h7BDE);
        check_lit("held_then_unlock", 8'(unlocked), 8'h01);
        enter(4'hE);

        // Reset mid-entry discards the partial attempt.
        enter(4'hE); enter(4'hD);
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        check_lit("mid_rst_led", led, 8'h00);
        enter(4'hB); enter(4'h7);
        check_lit("mid_rst_partial_led", led, 8'h0C);
        check_lit("mid_rst_no_unlock", 8'(unlocked), 8'h00);
        enter(4'hE); enter(4'hD);
        check_lit("mid_rst_fail", 8'(fail_cnt), 8'h01);
        enter_code(16'h7BDE);
        check_lit("mid_rst_full_unlock", 8'(unlocked), 8'h01);

        cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
